// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: SPI peripheral transmitter with a word FIFO, oversampled SCK/CSN and idle-word underrun fill.
module spi_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit CPOL = 0,
  parameter bit CPHA = 0,
  parameter bit LSB_FIRST = 0,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       spi_sck,
  input  logic                       spi_csn,
  output logic                       spi_sdo,
  output logic                       spi_sdo_oe,
  output logic                       word_done,
  output logic                       underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic [2:0] sck_p, csn_p;
  logic sample_p, shift_p, start_p, stop_p;
  logic armed, sampled;
  logic [1:0] warm;
  logic [BW-1:0] bitcnt;
  logic [WIDTH-1:0] sh, nxt, word;
  logic push, pop, load, empty, lead, trail;
  assign level = wp - rp;
  assign tx_ready = level != (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign push = tx_valid && tx_ready;
  assign word = empty ? IDLE_WORD : mem[rp[AW-1:0]];
  assign lead = (sck_p[2] == CPOL) && (sck_p[1] != CPOL);
  assign trail = (sck_p[2] != CPOL) && (sck_p[1] == CPOL);
  assign load = (state == IDLE) ? start_p : (!stop_p && shift_p && sampled && bitcnt == '0);
  assign pop = load && !empty;
  assign nxt = LSB_FIRST ? (sh >> 1) : (sh << 1);
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= tx_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_p <= {3{CPOL}};
      csn_p <= '1;
      sample_p <= 1'b0;
      shift_p <= 1'b0;
      start_p <= 1'b0;
      stop_p <= 1'b0;
      warm <= '0;
      armed <= 1'b0;
      state <= IDLE;
      sampled <= 1'b0;
      bitcnt <= '0;
      sh <= '0;
      spi_sdo <= 1'b0;
      spi_sdo_oe <= 1'b0;
      word_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sck_p <= {sck_p[1:0], spi_sck};
      csn_p <= {csn_p[1:0], spi_csn};
      sample_p <= CPHA ? trail : lead;
      shift_p <= CPHA ? lead : trail;
      start_p <= csn_p[2] && !csn_p[1] && armed;
      stop_p <= !csn_p[2] && csn_p[1];
      // the synchroniser still holds its reset value for a few clocks, so arm only once it reflects the pin
      warm <= warm + 2'(warm != 2'd3);
      armed <= armed || (csn_p[1] && warm == 2'd3);
      word_done <= 1'b0;
      underrun <= load && empty;
      if (state == ACTIVE && stop_p) begin
        state <= IDLE;
        spi_sdo_oe <= 1'b0;
        spi_sdo <= 1'b0;
        bitcnt <= '0;
      end else if (load) begin
        state <= ACTIVE;
        sh <= word;
        spi_sdo <= LSB_FIRST ? word[0] : word[WIDTH-1];
        spi_sdo_oe <= 1'b1;
        bitcnt <= '0;
        sampled <= 1'b0;
      end else if (state == ACTIVE && sample_p) begin
        sampled <= 1'b1;
        bitcnt <= (bitcnt == LAST) ? '0 : bitcnt + 1'b1;
        word_done <= bitcnt == LAST;
      end else if (state == ACTIVE && shift_p && sampled) begin
        sh <= nxt;
        spi_sdo <= LSB_FIRST ? nxt[0] : nxt[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_spi_tx_fifo.sv
// tb_spi_tx_fifo: checks a mode-0 byte instance and a mode-3 LSB-first 16-bit instance against spec-level expectations.
module tb_spi_tx_fifo;
  localparam int HP = 6;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [7:0] d0;
  logic v0, r0, sck0, csn0, sdo0, oe0, wd0, ur0;
  logic [2:0] l0;
  logic [15:0] d3;
  logic v3, r3, sck3, csn3, sdo3, oe3, wd3, ur3;
  logic [2:0] l3;
  int nwd0 = 0, nur0 = 0, nwd3 = 0, nur3 = 0;
  int ntest = 0, nfail = 0;

  spi_tx_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .IDLE_WORD(8'hFF)) u0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(r0), .level(l0),
    .spi_sck(sck0), .spi_csn(csn0), .spi_sdo(sdo0), .spi_sdo_oe(oe0), .word_done(wd0), .underrun(ur0));
  spi_tx_fifo #(.WIDTH(16), .DEPTH(4), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .IDLE_WORD(16'h0000)) u3 (
    .clk(clk), .rst(rst), .tx_data(d3), .tx_valid(v3), .tx_ready(r3), .level(l3),
    .spi_sck(sck3), .spi_csn(csn3), .spi_sdo(sdo3), .spi_sdo_oe(oe3), .word_done(wd3), .underrun(ur3));

  always @(negedge clk) begin
    if (wd0) nwd0++;
    if (ur0) nur0++;
    if (wd3) nwd3++;
    if (ur3) nur3++;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ntest++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic push(input int m, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    if (m == 0) begin d0 = d[7:0]; v0 = 1; end else begin d3 = d; v3 = 1; end
    while (!(m == 0 ? r0 : r3) && t < 500) begin @(negedge clk); t++; end
    chk("push_wait", 32'(t < 500), 1);
    @(posedge clk);
    #1;
    if (m == 0) v0 = 0; else v3 = 0;
  endtask

  task automatic xfer(input int m, input int n, output logic [63:0] b, output int urs);
    int ub = (m == 0) ? nur0 : nur3;
    b = '0;
    if (m == 0) csn0 = 0; else csn3 = 0;
    repeat (HP) @(negedge clk);
    urs = ((m == 0) ? nur0 : nur3) - ub;
    for (int i = 0; i < n; i++) begin
      if (m == 0) begin
        sck0 = 1; b[i] = sdo0;
        repeat (HP) @(negedge clk);
        sck0 = 0;
        repeat (HP) @(negedge clk);
      end else begin
        sck3 = 0;
        repeat (HP) @(negedge clk);
        sck3 = 1; b[i] = sdo3;
        repeat (HP) @(negedge clk);
      end
    end
  endtask

  task automatic desel(input int m);
    if (m == 0) csn0 = 1; else csn3 = 1;
    repeat (10) @(negedge clk);
  endtask

  function automatic logic [7:0] w8(input logic [63:0] b, input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[7-j] = b[8*k+j];
    return r;
  endfunction

  function automatic logic [15:0] w16(input logic [63:0] b, input int k);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[j] = b[16*k+j];
    return r;
  endfunction

  typedef struct {
    bit do_push;
    logic [7:0] d;
    logic [7:0] exp;
    int exp_ur;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [63:0] b;
    logic [15:0] q[$];
    logic [15:0] e;
    int urs, wb, ub, nw, np, eu;
    tbl[0] = '{1, 8'hA5, 8'b1010_0101, 0};
    tbl[1] = '{1, 8'h3C, 8'b0011_1100, 0};
    tbl[2] = '{1, 8'h01, 8'b0000_0001, 0};
    tbl[3] = '{0, 8'h00, 8'b1111_1111, 1};
    tbl[4] = '{1, 8'h80, 8'b1000_0000, 0};
    csn0 = 1; sck0 = 0; csn3 = 1; sck3 = 1; v0 = 0; v3 = 0; d0 = 0; d3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_sdo", sdo0, 0);
    chk("rst_oe", oe0, 0);
    chk("rst_wd", wd0, 0);
    chk("rst_ur", ur0, 0);
    chk("rst_level", l0, 0);
    chk("rst_ready", r0, 1);
    chk("rst_oe3", oe3, 0);
    chk("rst_level3", l3, 0);
    rst = 0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].do_push) push(0, {8'h00, tbl[i].d});
      chk("tbl_level_pre", l0, 32'(tbl[i].do_push));
      wb = nwd0;
      xfer(0, 8, b, urs);
      chk("tbl_rx", w8(b, 0), tbl[i].exp);
      chk("tbl_ur_start", urs, tbl[i].exp_ur);
      chk("tbl_wd", nwd0 - wb, 1);
      desel(0);
      chk("tbl_level_post", l0, 0);
      chk("tbl_oe_off", oe0, 0);
    end

    push(1, 16'h1234);
    push(1, 16'hBEEF);
    wb = nwd3; ub = nur3;
    xfer(1, 32, b, urs);
    chk("m3_w0", w16(b, 0), 16'h1234);
    chk("m3_w1", w16(b, 1), 16'hBEEF);
    chk("m3_wd", nwd3 - wb, 2);
    chk("m3_ur", nur3 - ub, 0);
    desel(1);
    chk("m3_level", l3, 0);

    wb = nwd0;
    fork
      xfer(0, 16, b, urs);
      begin repeat (40) @(negedge clk); push(0, 16'h005A); end
    join
    chk("ur_start", urs, 1);
    chk("ur_w0", w8(b, 0), 8'hFF);
    chk("ur_w1", w8(b, 1), 8'h5A);
    chk("ur_wd", nwd0 - wb, 2);
    desel(0);

    push(0, 16'h11); push(0, 16'h22); push(0, 16'h33); push(0, 16'h44);
    chk("full_ready", r0, 0);
    chk("full_level", l0, 4);
    fork
      push(0, 16'h55);
      begin
        repeat (5) @(negedge clk);
        chk("full_hold_level", l0, 4);
        chk("full_hold_ready", r0, 0);
        xfer(0, 40, b, urs);
      end
    join
    chk("full_w0", w8(b, 0), 8'h11);
    chk("full_w1", w8(b, 1), 8'h22);
    chk("full_w2", w8(b, 2), 8'h33);
    chk("full_w3", w8(b, 3), 8'h44);
    chk("full_w4", w8(b, 4), 8'h55);
    desel(0);
    chk("full_level_post", l0, 0);

    push(0, 16'h3C);
    push(0, 16'h81);
    wb = nwd0;
    xfer(0, 3, b, urs);
    chk("abort_bits", b[2:0], 3'b100);
    chk("abort_oe_on", oe0, 1);
    csn0 = 1;
    repeat (4) @(negedge clk);
    chk("abort_oe_off", oe0, 0);
    chk("abort_sdo", sdo0, 0);
    repeat (6) @(negedge clk);
    chk("abort_wd", nwd0 - wb, 0);
    chk("abort_level", l0, 1);
    xfer(0, 8, b, urs);
    chk("abort_next", w8(b, 0), 8'h81);
    desel(0);

    push(0, 16'h55);
    push(0, 16'h66);
    xfer(0, 5, b, urs);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("mrst_sdo", sdo0, 0);
    chk("mrst_oe", oe0, 0);
    chk("mrst_level", l0, 0);
    chk("mrst_ready", r0, 1);
    wb = nwd0; ub = nur0;
    xfer(0, 8, b, urs);
    chk("mrst_no_oe", oe0, 0);
    chk("mrst_no_wd", nwd0 - wb, 0);
    chk("mrst_no_ur", nur0 - ub, 0);
    desel(0);
    push(0, 16'h96);
    xfer(0, 8, b, urs);
    chk("mrst_after", w8(b, 0), 8'h96);
    desel(0);

    for (int it = 0; it < 12; it++) begin
      np = $urandom_range(0, 4 - q.size());
      for (int k = 0; k < np; k++) begin
        e = 16'($urandom);
        push(1, e);
        q.push_back(e);
      end
      chk("rnd_level_pre", l3, q.size());
      nw = $urandom_range(1, 3);
      wb = nwd3; ub = nur3; eu = 0;
      xfer(1, 16 * nw, b, urs);
      for (int k = 0; k < nw; k++) begin
        if (q.size() > 0) e = q.pop_front();
        else begin e = 16'h0000; eu++; end
        chk("rnd_word", w16(b, k), e);
      end
      chk("rnd_wd", nwd3 - wb, nw);
      chk("rnd_ur", nur3 - ub, eu);
      desel(1);
      chk("rnd_level_post", l3, q.size());
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
